// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB register file with a read-only ID word at index 0,
// a configurable number of access-phase wait states and an error response
// for out-of-range, unaligned or read-only-target accesses.
// Optional build macro APB_REGFILE_PSTRB_EN: when defined, writes honour
// PSTRB byte lanes; when undefined, PSTRB is ignored and whole words are written.
module apb_regfile_slave #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PSELx,
    input  logic                    PENABLE,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    pready_reg;
    logic                    pslverr_reg;
    logic [DATA_WIDTH-1:0]   prdata_reg;

    // Address decode: word index, alignment and range check
    logic [ADDR_WIDTH-1:0]   index_full;
    logic [IDX_W-1:0]        reg_sel;
    logic                    addr_aligned;
    logic                    addr_valid;
    logic                    resp_err;
    logic [DATA_WIDTH-1:0]   read_word;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    commit;
    logic [BYTES-1:0]        byte_en;

    logic [DATA_WIDTH-1:0]   reg_file [NUM_REGS];

    assign index_full   = PADDR >> SHIFT;
    assign reg_sel      = index_full[IDX_W-1:0];
    assign addr_aligned = (PADDR & ADDR_WIDTH'(BYTES - 1)) == '0;
    assign addr_valid   = addr_aligned && (index_full < ADDR_WIDTH'(NUM_REGS));
    // Index 0 holds the ID word, so writing it is reported as an error
    assign resp_err     = !addr_valid || (PWRITE && (index_full == '0));
    assign read_word    = addr_valid ? reg_file[reg_sel] : '0;
    // Writes return zero on PRDATA; errored accesses always return zero
    assign resp_rdata   = (!PWRITE && !resp_err) ? read_word : '0;

    // A write lands only on the completing access edge of an error-free transfer
    assign commit = pready_reg && !pslverr_reg && PSELx && PENABLE && PWRITE;

`ifdef APB_REGFILE_PSTRB_EN
    assign byte_en = PSTRB;
`else
    assign byte_en = '1;
    logic unused_pstrb;
    assign unused_pstrb = ^PSTRB;
`endif

    // Transfer FSM with registered PREADY/PSLVERR/PRDATA
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pready_reg  <= 1'b0;
                    pslverr_reg <= 1'b0;
                    prdata_reg  <= '0;
                    // Only a setup phase starts a transfer; a stray PENABLE is ignored
                    if (PSELx && !PENABLE) begin
                        if (WAIT_STATES == 0) begin
                            // Zero wait states: response is ready in the first access cycle
                            state_reg   <= ST_RESP;
                            count_reg   <= '0;
                            pready_reg  <= 1'b1;
                            pslverr_reg <= resp_err;
                            prdata_reg  <= resp_rdata;
                        end else begin
                            state_reg <= ST_WAIT;
                            count_reg <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSELx) begin
                        // Master abandoned the transfer: nothing is written
                        state_reg <= ST_IDLE;
                        count_reg <= '0;
                    end else if (PENABLE) begin
                        // The access cycle that drains the counter to zero completes
                        if (count_reg <= CNT_W'(1)) begin
                            state_reg   <= ST_RESP;
                            count_reg   <= '0;
                            pready_reg  <= 1'b1;
                            pslverr_reg <= resp_err;
                            prdata_reg  <= resp_rdata;
                        end else begin
                            count_reg <= count_reg - CNT_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    state_reg   <= ST_IDLE;
                    pready_reg  <= 1'b0;
                    pslverr_reg <= 1'b0;
                    prdata_reg  <= '0;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    count_reg   <= '0;
                    pready_reg  <= 1'b0;
                    pslverr_reg <= 1'b0;
                    prdata_reg  <= '0;
                end
            endcase
        end
    end

    // Register storage: index 0 is the constant ID, the rest are byte-writable words
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_id
                assign reg_file[gi] = DATA_WIDTH'(ID_VALUE);
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] word_reg;
                logic                  sel;
                assign sel = addr_valid && (reg_sel == IDX_W'(gi));
                // Commit enabled byte lanes on the completing write edge
                always_ff @(posedge i_clk or negedge i_reset_n) begin
                    if (!i_reset_n) begin
                        word_reg <= '0;
                    end else if (commit && sel) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (byte_en[b]) begin
                                word_reg[b*8 +: 8] <= PWDATA[b*8 +: 8];
                            end
                        end
                    end
                end
                assign reg_file[gi] = word_reg;
            end
        end
    endgenerate

    assign PREADY  = pready_reg;
    assign PSLVERR = pslverr_reg;
    assign PRDATA  = prdata_reg;

endmodule
